// File: rtl/fetch_pkg.sv
// Shared fetch constants and FSM state encoding.
// Used by instr_fetch, instr_counter and anything decoding fetch state.
package fetch_pkg;

  localparam int PC_W    = 11;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/instr_counter.sv
// Saturating event counter: clear wins over enable, holds at all-ones.
// One-cycle update latency, no backpressure.
module instr_counter
  import fetch_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         Clk,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM (IDLE/RUN/HALT) with registered PC, Instr is a zero-latency passthrough.
// Stall holds PC and state; FETCH_INSTR_COUNT_EN adds the InstrCount output.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic               Stall,
  input  logic               BranchEn,
  input  logic [PC_W-1:0]    BranchTarget,
  output logic [PC_W-1:0]    InstAddress,
  input  logic [INSTR_W-1:0] InstIn,
  output logic [INSTR_W-1:0] Instr,
  output logic               Valid,
  output logic               Done
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0]   InstrCount
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_nxt;
  logic              is_halt;

  // Halt opcode is all ones at whatever width the store is configured for.
  assign is_halt = &InstIn;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_nxt = ST_RUN;
          pc_nxt    = StartAddr;
        end
      end
      ST_RUN: begin
        // Halt takes precedence over a branch on the same instruction.
        if (!Stall) begin
          if (is_halt) begin
            state_nxt = ST_HALT;
          end else if (BranchEn) begin
            pc_nxt = BranchTarget;
          end else begin
            pc_nxt = pc + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign InstAddress = pc;
  assign Instr       = InstIn;
  assign Valid       = (state == ST_RUN);
  assign Done        = (state == ST_HALT);

`ifdef FETCH_INSTR_COUNT_EN
  logic start_acc;
  logic cnt_en;

  assign start_acc = Start && (state != ST_RUN);
  assign cnt_en    = (state == ST_RUN) && !Stall;

  instr_counter #(
    .W (CNT_W)
  ) u_instr_counter (
    .Clk    (Clk),
    .clear  (Reset || start_acc),
    .enable (cnt_en),
    .count  (InstrCount)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed literal checks plus randomized run against a behavioural model.
module tb_instr_fetch;

  localparam int DEPTH = 2048;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [10:0] StartAddr;
  logic        Stall;
  logic        BranchEn;
  logic [10:0] BranchTarget;
  logic [10:0] InstAddress;
  logic [8:0]  InstIn;
  logic [8:0]  Instr;
  logic        Valid;
  logic        Done;
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] InstrCount;
`endif

  logic [8:0] imem [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  always #5 Clk = ~Clk;

  assign InstIn = imem[InstAddress];

  instr_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Stall        (Stall),
    .BranchEn     (BranchEn),
    .BranchTarget (BranchTarget),
    .InstAddress  (InstAddress),
    .InstIn       (InstIn),
    .Instr        (Instr),
    .Valid        (Valid),
    .Done         (Done)
`ifdef FETCH_INSTR_COUNT_EN
    ,
    .InstrCount   (InstrCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode <= 0;
      m_pc   <= 0;
      m_cnt  <= 0;
    end else begin
      case (m_mode)
        0, 2: begin
          if (Start) begin
            m_mode <= 1;
            m_pc   <= int'(StartAddr);
            m_cnt  <= 0;
          end
        end
        1: begin
          if (!Stall) begin
            m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (imem[m_pc] == 9'h1FF) m_mode <= 2;
            else if (BranchEn)        m_pc   <= int'(BranchTarget);
            else                      m_pc   <= (m_pc + 1) % DEPTH;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("cmp_valid", {31'd0, Valid}, {31'd0, (m_mode == 1)});
      check("cmp_done",  {31'd0, Done},  {31'd0, (m_mode == 2)});
      check("cmp_addr",  {21'd0, InstAddress}, m_pc);
      check("cmp_instr", {23'd0, Instr}, {23'd0, imem[m_pc]});
`ifdef FETCH_INSTR_COUNT_EN
      check("cmp_count", {16'd0, InstrCount}, m_cnt);
`endif
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
    StartAddr = '0; BranchTarget = '0;
    for (int i = 0; i < DEPTH; i++) imem[i] = 9'($urandom_range(0, 510));

    tick(); tick();
    chk_en = 1'b1;
    check("rst_valid", {31'd0, Valid}, 0);
    check("rst_done",  {31'd0, Done}, 0);
    check("rst_addr",  {21'd0, InstAddress}, 0);

    Reset = 1'b0; Start = 1'b1; StartAddr = 11'd5;
    tick();
    check("start_valid", {31'd0, Valid}, 1);
    check("start_addr5", {21'd0, InstAddress}, 5);
    Start = 1'b0;
    tick(); check("seq_addr6", {21'd0, InstAddress}, 6);
    tick(); check("seq_addr7", {21'd0, InstAddress}, 7);

    BranchEn = 1'b1; BranchTarget = 11'd10;
    tick(); check("br_addr10", {21'd0, InstAddress}, 10);
    BranchTarget = 11'd100; Stall = 1'b1;
    tick(); check("stall_hold10", {21'd0, InstAddress}, 10);
    Stall = 1'b0;
    tick(); check("br_addr100", {21'd0, InstAddress}, 100);
    BranchEn = 1'b0;

    Start = 1'b1; StartAddr = 11'd300;
    tick(); check("start_in_run", {21'd0, InstAddress}, 101);
    Start = 1'b0;

    BranchEn = 1'b1; BranchTarget = 11'd2047;
    tick(); check("br_addr2047", {21'd0, InstAddress}, 2047);
    BranchEn = 1'b0;
    tick();
    check("wrap_addr0", {21'd0, InstAddress}, 0);
    check("wrap_valid", {31'd0, Valid}, 1);

    imem[3] = 9'h1FF;
    tick(); tick(); tick();
    check("pre_halt_addr3", {21'd0, InstAddress}, 3);
    BranchEn = 1'b1; BranchTarget = 11'd77;
    tick();
    check("halt_done",  {31'd0, Done}, 1);
    check("halt_valid", {31'd0, Valid}, 0);
    check("halt_addr3", {21'd0, InstAddress}, 3);
    BranchEn = 1'b0;
    tick(); check("halt_hold3", {21'd0, InstAddress}, 3);
    Start = 1'b1; StartAddr = 11'd0;
    tick();
    check("restart_valid", {31'd0, Valid}, 1);
    check("restart_done",  {31'd0, Done}, 0);
    check("restart_addr0", {21'd0, InstAddress}, 0);
    Start = 1'b0;

    BranchEn = 1'b1; BranchTarget = 11'd50;
    tick(); check("br_addr50", {21'd0, InstAddress}, 50);
    Reset = 1'b1; Start = 1'b1;
    tick();
    check("midrst_addr",  {21'd0, InstAddress}, 0);
    check("midrst_valid", {31'd0, Valid}, 0);
    check("midrst_done",  {31'd0, Done}, 0);
    Reset = 1'b0; Start = 1'b0; BranchEn = 1'b0;
    tick();
    check("idle_hold_valid", {31'd0, Valid}, 0);
    check("idle_hold_addr",  {21'd0, InstAddress}, 0);

    // Four executed instructions (20,21,22,23=halt) with one stalled cycle.
    imem[23] = 9'h1FF;
    Start = 1'b1; StartAddr = 11'd20;
    tick(); Start = 1'b0;
`ifdef FETCH_INSTR_COUNT_EN
    check("cnt_after_start", {16'd0, InstrCount}, 0);
`endif
    tick(); check("cnt_seq21", {21'd0, InstAddress}, 21);
    Stall = 1'b1;
    tick(); check("cnt_stall21", {21'd0, InstAddress}, 21);
    Stall = 1'b0;
    tick(); tick();
    check("cnt_seq23", {21'd0, InstAddress}, 23);
    tick();
    check("cnt_halt_done", {31'd0, Done}, 1);
`ifdef FETCH_INSTR_COUNT_EN
    check("cnt_four", {16'd0, InstrCount}, 4);
`endif
    Start = 1'b1; StartAddr = 11'd0;
    tick(); Start = 1'b0;
`ifdef FETCH_INSTR_COUNT_EN
    check("cnt_cleared", {16'd0, InstrCount}, 0);
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 29) == 0) imem[i] = 9'h1FF;
    end
    for (int c = 0; c < 4000; c++) begin
      Reset        = ($urandom_range(0, 99) == 0);
      Start        = ($urandom_range(0, 9) == 0);
      StartAddr    = 11'($urandom_range(0, 2047));
      Stall        = ($urandom_range(0, 4) == 0);
      BranchEn     = ($urandom_range(0, 6) == 0);
      BranchTarget = ($urandom_range(0, 3) == 0) ? 11'd2047 : 11'($urandom_range(0, 2047));
      tick();
    end

    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 11: instruction address width (2**11-entry instruction store).
REQ-002 Parameter INSTR_W, default 9: instruction width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  one-cycle request to begin execution at StartAddr.
REQ-006 StartAddr  input  PC_W  program entry address, sampled with Start.
REQ-007 Stall  input  1  hold PC and state this cycle.
REQ-008 BranchEn  input  1  take branch at end of current instruction.
REQ-009 BranchTarget  input  PC_W  absolute branch destination.
REQ-010 InstAddress  output  PC_W  registered PC; drives instruction store address.
REQ-011 InstIn  input  INSTR_W  instruction word returned combinationally by the store for InstAddress.
REQ-012 Instr  output  INSTR_W  current instruction to decode (InstIn passthrough).
REQ-013 Valid  output  1  high while in RUN; Instr meaningful only when high.
REQ-014 Done  output  1  high while in HALT.

Function
REQ-015 FSM states IDLE, RUN, HALT; Valid = (state==RUN), Done = (state==HALT), both decoded from state register.
REQ-016 IDLE: Start=1 -> RUN, PC <= StartAddr; else hold, PC unchanged.
REQ-017 RUN, Stall=1: PC and state hold regardless of BranchEn, Start or instruction value.
REQ-018 RUN, Stall=0, InstIn==HALT_INSTR (all ones): -> HALT, PC holds at halt address; BranchEn ignored.
REQ-019 RUN, Stall=0, BranchEn=1: PC <= BranchTarget (1-cycle latency; target instruction visible next cycle).
REQ-020 RUN, Stall=0 otherwise: PC <= PC+1 modulo 2**PC_W (2047 -> 0, no flag).
REQ-021 Start asserted while in RUN is ignored.
REQ-022 HALT: Start=1 -> RUN, PC <= StartAddr, Done deasserts next cycle; else hold.
REQ-023 Instr = InstIn at all times; no added latency on instruction path.

Reset
REQ-024 Reset=1 at a clock edge forces state IDLE, PC 0, Valid 0, Done 0, overriding Start, Stall and BranchEn, including mid-RUN.
REQ-025 Reset dominates all other inputs in the same cycle; first Start is honoured on the cycle after Reset deasserts.

Configuration
REQ-026 Macro FETCH_INSTR_COUNT_EN defined: extra output InstrCount (16 bits), counting RUN cycles with Stall=0 (halt instruction included); cleared by Reset and by accepted Start; saturates at 16'hFFFF.
REQ-027 Macro undefined: InstrCount port and counter logic absent; all other behaviour identical.

Structure
REQ-028 Shared package fetch_pkg holds PC_W, INSTR_W, HALT_INSTR constant and the state enum/encoding.
REQ-029 Counter under REQ-026 is a sub-module instr_counter (clear, enable, saturating 16-bit); FSM and PC remain in instr_fetch.

Verification
REQ-030 Reset, Start with StartAddr=5 -> Valid rises next cycle, InstAddress 5,6,7 on successive cycles with Stall=0.
REQ-031 In RUN at PC=10, BranchEn=1, BranchTarget=100 -> next InstAddress 100; with Stall=1 same cycle -> PC stays 10.
REQ-032 PC=2047, no branch -> next InstAddress 0, Valid stays 1.
REQ-033 InstIn=9'h1FF at PC=3 -> Done=1, Valid=0 next cycle, InstAddress stays 3; then Start with StartAddr=0 -> RUN at 0, Done=0.
REQ-034 Reset asserted mid-RUN at PC=50 with BranchEn=1 -> next cycle IDLE, PC 0, Valid 0, Done 0; Start in RUN ignored.
REQ-035 With FETCH_INSTR_COUNT_EN: 4 instructions incl. one stalled cycle then halt -> InstrCount=4; cleared to 0 on next Start.
